// File: rtl/shifter_pkg.sv
// Shared encodings and helpers for the iterative shifter: shift modes, FSM states,
// and the accept-to-result latency function.
package shifter_pkg;

   typedef enum logic [1:0] {
      SH_SLL  = 2'b00,
      SH_SRL  = 2'b01,
      SH_SRA  = 2'b10,
      SH_ROTL = 2'b11
   } shift_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } shift_state_e;

   // Edges from the accept edge (inclusive) until OutValid is visible.
   function automatic int unsigned shift_latency(input int unsigned shamt,
                                                 input int unsigned step);
      return 1 + (shamt + step - 1) / step;
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data_i by 0..STEP positions in the given mode.
// Rotate wrap logic exists only when ITERATIVE_SHIFTER_ROTATE_EN is defined.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 4,
   localparam int AMT_W = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [AMT_W-1:0] amt_i,
   input  shift_mode_e      mode_i,
   input  logic             fill_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] sll_data;
   logic [WIDTH-1:0] srl_data;
   logic [WIDTH-1:0] fill_mask;

   assign sll_data  = data_i << amt_i;
   assign srl_data  = data_i >> amt_i;
   // Ones in the vacated MSB positions; only applied when the sign is set.
   assign fill_mask = fill_i ? ~({WIDTH{1'b1}} >> amt_i) : '0;

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
   logic [WIDTH-1:0] rot_data;
   assign rot_data = sll_data | (data_i >> (WIDTH - int'(amt_i)));
`endif

   always_comb begin
      data_o = sll_data;
      case (mode_i)
         SH_SRL:  data_o = srl_data;
         SH_SRA:  data_o = srl_data | fill_mask;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
         SH_ROTL: data_o = rot_data;
`endif
         default: data_o = sll_data;
      endcase
   end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle variable shifter, STEP positions per clock, valid/ready on both sides.
// Define ITERATIVE_SHIFTER_ROTATE_EN to make Mode 11 a left rotate (otherwise it is SLL).
module iterative_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 4,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               InValid,
   output logic               InReady,
   input  logic [WIDTH-1:0]   InputData,
   input  logic [SHAMT_W-1:0] Shamt,
   input  logic [1:0]         Mode,
   output logic               OutValid,
   input  logic               OutReady,
   output logic [WIDTH-1:0]   OutputData
);

   localparam int AMT_W = $clog2(STEP + 1);
   localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W + 1)'(STEP);

   shift_state_e       state_q;
   logic [WIDTH-1:0]   data_q;
   logic [SHAMT_W-1:0] rem_q;
   shift_mode_e        mode_q;
   logic               sign_q;
   logic               in_ready_q;
   logic               out_valid_q;

   logic [AMT_W-1:0]   step_amt;
   logic [WIDTH-1:0]   data_d;
   logic [SHAMT_W-1:0] rem_d;

   // Shift by min(remaining, STEP); the comparison is one bit wider so STEP==WIDTH fits.
   assign step_amt = ({1'b0, rem_q} >= STEP_L) ? AMT_W'(STEP) : AMT_W'(rem_q);
   assign rem_d    = rem_q - SHAMT_W'(step_amt);

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .data_i (data_q),
      .amt_i  (step_amt),
      .mode_i (mode_q),
      .fill_i (sign_q & (mode_q == SH_SRA)),
      .data_o (data_d)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         data_q      <= '0;
         rem_q       <= '0;
         mode_q      <= SH_SLL;
         sign_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (InValid) begin
                  data_q     <= InputData;
                  rem_q      <= Shamt;
                  mode_q     <= shift_mode_e'(Mode);
                  sign_q     <= InputData[WIDTH-1];
                  in_ready_q <= 1'b0;
                  if (Shamt == '0) begin
                     state_q     <= ST_DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               data_q <= data_d;
               rem_q  <= rem_d;
               if (rem_d == '0) begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (OutReady) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign InReady    = in_ready_q;
   assign OutValid   = out_valid_q;
   assign OutputData = data_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed table-driven bench for iterative_shifter (WIDTH=32, STEP=4), plus
// hand-written backpressure and mid-operation reset sequences.
module tb_iterative_shifter;

   logic        CLK;
   logic        RST_N;
   logic        InValid;
   logic        InReady;
   logic [31:0] InputData;
   logic [4:0]  Shamt;
   logic [1:0]  Mode;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] OutputData;

   int n_vec;
   int n_miss;

   iterative_shifter #(.WIDTH(32), .STEP(4)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .InValid    (InValid),
      .InReady    (InReady),
      .InputData  (InputData),
      .Shamt      (Shamt),
      .Mode       (Mode),
      .OutValid   (OutValid),
      .OutReady   (OutReady),
      .OutputData (OutputData)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] din;
      logic [4:0]  shamt;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!InReady && n < 30) begin
         @(posedge CLK); #1; n++;
      end
      if (!InReady) check("in_ready_timeout", 32'(InReady), 32'd1);
   endtask

   // Issue one request, count edges to OutValid (accept edge = 1), then check.
   task automatic issue(input string name, input logic [1:0] m, input logic [31:0] d,
                        input logic [4:0] s, output int lat, output logic busy_ready);
      wait_ready();
      Mode = m; InputData = d; Shamt = s; InValid = 1'b1;
      @(posedge CLK); #1;
      InValid = 1'b0;
      Mode = ~m; InputData = ~d; Shamt = ~s;
      lat = 1;
      busy_ready = 1'b0;
      while (!OutValid && lat < 20) begin
         if (InReady) busy_ready = 1'b1;
         @(posedge CLK); #1; lat++;
      end
   endtask

   task automatic handoff(input string name);
      OutReady = 1'b1;
      @(posedge CLK); #1;
      OutReady = 1'b0;
      check({name, "_handoff"}, {30'd0, OutValid, InReady}, 32'b01);
   endtask

   initial begin
      int lat;
      logic busy_ready;
      n_vec = 0;
      n_miss = 0;

      vt[0]  = '{2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004, 2};
      vt[1]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9};
      vt[2]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9};
      vt[3]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
      vt[4]  = '{2'b00, 32'hDEAD_BEEF, 5'd4,  32'hEADB_EEF0, 2};
      vt[5]  = '{2'b10, 32'hF000_0000, 5'd5,  32'hFF80_0000, 3};
      vt[6]  = '{2'b10, 32'h7000_0000, 5'd8,  32'h0070_0000, 3};
      vt[7]  = '{2'b01, 32'h1234_5678, 5'd12, 32'h0001_2345, 4};
      vt[8]  = '{2'b00, 32'h1234_5679, 5'd31, 32'h8000_0000, 9};
      vt[9]  = '{2'b10, 32'h8000_0000, 5'd1,  32'hC000_0000, 2};
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      vt[10] = '{2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003, 2};
      vt[11] = '{2'b11, 32'h1234_5678, 5'd8,  32'h3456_7812, 3};
`else
      vt[10] = '{2'b11, 32'h8000_0001, 5'd1,  32'h0000_0002, 2};
      vt[11] = '{2'b11, 32'h1234_5678, 5'd8,  32'h3456_7800, 3};
`endif

      RST_N = 1'b0; InValid = 1'b0; OutReady = 1'b0;
      InputData = '0; Shamt = '0; Mode = '0;
      #1;
      check("reset_outvalid", 32'(OutValid), 32'd0);
      check("reset_outdata", OutputData, 32'd0);
      @(posedge CLK); @(posedge CLK); #1;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      check("post_reset_inready", 32'(InReady), 32'd1);

      for (int i = 0; i < 12; i++) begin
         issue($sformatf("vec%0d", i), vt[i].mode, vt[i].din, vt[i].shamt, lat, busy_ready);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
         check($sformatf("vec%0d_data", i), OutputData, vt[i].exp);
         check($sformatf("vec%0d_busy_inready", i), 32'({busy_ready, InReady}), 32'd0);
         handoff($sformatf("vec%0d", i));
      end

      // Backpressure: result must hold and no new request may be accepted.
      issue("bp", 2'b00, 32'h0000_0001, 5'd2, lat, busy_ready);
      check("bp_latency", 32'(lat), 32'd2);
      InValid = 1'b1; InputData = 32'h5555_5555; Shamt = 5'd3; Mode = 2'b01;
      for (int c = 0; c < 5; c++) begin
         @(posedge CLK); #1;
         check($sformatf("bp_hold%0d", c), {OutputData[29:0], OutValid, InReady},
               {30'h0000_0004, 1'b1, 1'b0});
      end
      InValid = 1'b0;
      handoff("bp");
      @(posedge CLK); #1;
      check("bp_no_accept", 32'({OutValid, InReady}), 32'b01);

      // Reset mid-shift aborts the request.
      issue("rst_pre", 2'b00, 32'hFFFF_FFFF, 5'd20, lat, busy_ready);
      handoff("rst_pre");
      Mode = 2'b00; InputData = 32'hFFFF_FFFF; Shamt = 5'd20; InValid = 1'b1;
      @(posedge CLK); #1;
      InValid = 1'b0;
      @(posedge CLK); @(posedge CLK); #1;
      check("mid_shift_busy", 32'({OutValid, InReady}), 32'b00);
      RST_N = 1'b0;
      #1;
      check("rst_abort_outvalid", 32'(OutValid), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK); #1;
      check("rst_release", 32'({OutValid, InReady}), 32'b01);
      for (int c = 0; c < 6; c++) begin
         @(posedge CLK); #1;
      end
      check("rst_no_result", 32'(OutValid), 32'd0);
      issue("after_rst", 2'b00, 32'h0000_0001, 5'd1, lat, busy_ready);
      check("after_rst_latency", 32'(lat), 32'd2);
      check("after_rst_data", OutputData, 32'h0000_0002);
      handoff("after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/iterative_shifter.md
# iterative_shifter

Parametrised multi-cycle shifter that succeeds the fixed left-by-2 shifter: shifts a WIDTH-bit operand left or right by a run-time amount, STEP positions per clock, behind a valid/ready handshake. It serves the datapath's variable-shift instructions (sll/srl/sra and their variable forms) and any multi-cycle execute path that trades shifter area for latency.

## Interface
- WIDTH, 32: operand width; power of two, at least 8.
- STEP, 4: maximum positions shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- SHAMT_W, $clog2(WIDTH): width of Shamt; derived, not overridden.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- InValid  in  1  request present.
- InReady  out  1  block can accept a request.
- InputData  in  WIDTH  operand.
- Shamt  in  SHAMT_W  shift amount.
- Mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROTL (see Configuration).
- OutValid  out  1  result present.
- OutReady  in  1  consumer accepts the result.
- OutputData  out  WIDTH  result; held stable while OutValid=1.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: InReady=1. When InValid=1, capture InputData into the working register, Shamt into the remaining count, and Mode. Next state is DONE if Shamt==0, otherwise SHIFT.
- SHIFT: each cycle shift by k = min(remaining, STEP) and subtract k from remaining. When the post-step remaining is 0, next state is DONE.
- DONE: OutValid=1 and OutputData = working register. When OutReady=1, next state is IDLE.
- InReady is 1 only in IDLE; there is no accept in the cycle a result is handed off.
- Fill rules: SLL and SRL fill with 0. SRA fills with the captured operand's bit WIDTH-1 on every step. ROTL wraps the MSBs into the LSBs.
- Mode and Shamt are sampled only at accept. Input changes during SHIFT or DONE are ignored.
- OutputData equals the working register in all states. It is meaningful only when OutValid=1.
- Reset values: state IDLE, InReady=1 once RST_N is high, OutValid=0, OutputData=0, remaining=0.
- Reset asserted mid-operation aborts the operation immediately; no result is produced.

## Timing
- Latency from the accept edge to OutValid visible is 1 + ceil(Shamt/STEP) cycles. Shamt=0 gives 1 cycle.
- Worst case at WIDTH=32, STEP=4 is 1 + 8 = 9 cycles.
- Minimum issue interval is latency + 1: one DONE cycle with OutReady=1, then one IDLE cycle to accept.
- OutValid falls, and InReady rises, on the edge where OutReady=1 is sampled in DONE.
- Backpressure: DONE holds indefinitely with OutputData stable.

## Configuration
- ITERATIVE_SHIFTER_ROTATE_EN defined: Mode 11 performs a left rotate.
- Macro undefined: Mode 11 behaves exactly as SLL, and no rotate wrap logic is built.

## Structure
- Package shifter_pkg holds:
  - the Mode encodings as a 2-bit enum: SH_SLL, SH_SRL, SH_SRA, SH_ROTL;
  - the FSM state enum;
  - the latency helper function.
- Sub-module shift_step: combinational shifter that shifts by 0..STEP under mode control, with a sign-fill input. It is instantiated once and driven by the working register each SHIFT cycle.

## Test plan
- SLL, InputData=0x0000_0001, Shamt=2 (WIDTH=32, STEP=4) -> OutputData=0x0000_0004, OutValid 2 cycles after accept.
- SRA, InputData=0x8000_0000, Shamt=31 -> OutputData=0xFFFF_FFFF after 9 cycles. SRL with the same inputs -> 0x0000_0001.
- Shamt=0, InputData=0xDEAD_BEEF, SRL -> OutputData=0xDEAD_BEEF, latency 1.
- Result ready with OutReady held 0 for 5 cycles -> OutValid and OutputData stable, InReady=0. A new InValid in that window is not accepted.
- RST_N pulsed low during SHIFT of a Shamt=20 request -> OutValid=0, InReady=1 after release, and a following SLL 0x1 by 1 returns 0x2.
- Mode=11, InputData=0x8000_0001, Shamt=1 -> 0x0000_0003 with ITERATIVE_SHIFTER_ROTATE_EN defined, 0x0000_0002 without.
